// File: rtl/median_axis_out_fifo.sv
// ----------------------------------------------------------------------------
// median_axis_out_fifo
//
// Output adapter for the 3x3 median filter. The filter's stream has no
// backpressure, so every word is either stored in a small show-ahead FIFO
// or dropped in the cycle it arrives. The FIFO contents are re-emitted as
// an AXI4-Stream master that honours m_axis_tready.
//
// If the FIFO overflows, the rest of the damaged frame is discarded. Writing
// resumes only at the next start-of-frame (tuser), so a downstream consumer
// never sees the tail of one frame joined to the head of another.
//
// Ports
//   i_clk, i_aresetn      clock, asynchronous active-low reset
//   s_axis_*              filter stream in (tdata, tvalid, tuser=SOF, tlast=EOL)
//   m_axis_*              AXI4-Stream out (tdata, tvalid, tready, tuser, tlast)
//   o_fill                current occupancy, 0..DEPTH
//   o_overflow            sticky overflow flag
//   i_clear_overflow      single-cycle clear of o_overflow (a new overflow wins)
//   o_dropped_frames      saturating count of frames damaged by overflow
// ----------------------------------------------------------------------------
module median_axis_out_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_aresetn,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic [$clog2(DEPTH):0]   o_fill,
    output logic                     o_overflow,
    input  logic                     i_clear_overflow,
    output logic [CNT_WIDTH-1:0]     o_dropped_frames
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [AW:0]          FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    localparam logic [0:0] ST_PASS = 1'b0;
    localparam logic [0:0] ST_DROP = 1'b1;

    // Each entry holds {tuser, tlast, tdata}
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [0:0]    state;
    logic [0:0]    state_next;

    logic [EW-1:0] head;
    logic          rd_en;
    logic          wr_en;
    logic          space;
    logic          ovf_set;
    logic          drop_inc;

    assign head  = mem[rd_ptr];
    assign rd_en = m_axis_tvalid & m_axis_tready;
    // A full FIFO can still take a word when the head leaves in the same cycle
    assign space = (count < FULL_COUNT) | rd_en;

    // Show-ahead read side; payload is zeroed whenever nothing is valid
    always_comb begin
        m_axis_tvalid = (count != '0);
        m_axis_tdata  = '0;
        m_axis_tuser  = 1'b0;
        m_axis_tlast  = 1'b0;
        if (m_axis_tvalid) begin
            m_axis_tdata = head[DATA_WIDTH-1:0];
            m_axis_tlast = head[DATA_WIDTH];
            m_axis_tuser = head[DATA_WIDTH+1];
        end
    end

    // Write-side decision. In DROP, only a start-of-frame that fits can
    // restart writing; a start-of-frame that does not fit is a second lost frame.
    always_comb begin
        wr_en      = 1'b0;
        ovf_set    = 1'b0;
        drop_inc   = 1'b0;
        state_next = state;
        if (s_axis_tvalid) begin
            if (state == ST_PASS) begin
                if (space) begin
                    wr_en = 1'b1;
                end else begin
                    ovf_set    = 1'b1;
                    drop_inc   = 1'b1;
                    state_next = ST_DROP;
                end
            end else if (s_axis_tuser) begin
                if (space) begin
                    wr_en      = 1'b1;
                    state_next = ST_PASS;
                end else begin
                    drop_inc = 1'b1;
                end
            end
        end
    end

    // Storage array; needs no reset because the outputs are gated by count
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
        end
    end

    // Pointers, occupancy, state and status registers
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            state            <= ST_PASS;
            o_overflow       <= 1'b0;
            o_dropped_frames <= '0;
        end else begin
            state <= state_next;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_set) begin
                o_overflow <= 1'b1;
            end else if (i_clear_overflow) begin
                o_overflow <= 1'b0;
            end
            if (drop_inc && (o_dropped_frames != CNT_MAX)) begin
                o_dropped_frames <= o_dropped_frames + 1'b1;
            end
        end
    end

    assign o_fill = count;

endmodule

// File: tb/tb_median_axis_out_fifo.sv
// ----------------------------------------------------------------------------
// tb_median_axis_out_fifo
//
// Self-checking bench for median_axis_out_fifo (DATA_WIDTH=8, DEPTH=16).
// The stimulus tasks push every word that must come out onto a scoreboard
// queue. A monitor pops the queue on each output handshake and compares
// {tuser, tlast, tdata}. Each scenario task also checks fill, flags and
// counters inline. Inputs change only #1 after a rising edge, and outputs
// are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_median_axis_out_fifo;

    localparam int DW = 8;

    logic          i_clk;
    logic          i_aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tuser;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic [4:0]    o_fill;
    logic          o_overflow;
    logic          i_clear_overflow;
    logic [15:0]   o_dropped_frames;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW+1:0] exp_q[$];

    median_axis_out_fifo #(.DATA_WIDTH(8), .DEPTH(16), .CNT_WIDTH(16)) dut (
        .i_clk            (i_clk),
        .i_aresetn        (i_aresetn),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tlast     (s_axis_tlast),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tlast     (m_axis_tlast),
        .o_fill           (o_fill),
        .o_overflow       (o_overflow),
        .i_clear_overflow (i_clear_overflow),
        .o_dropped_frames (o_dropped_frames)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Scoreboard consumer: every output handshake must match the oldest expected word
    always @(negedge i_clk) begin
        logic [DW+1:0] exp_w;
        if (i_aresetn && m_axis_tvalid && m_axis_tready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL scoreboard_unexpected: got %h, expected no output",
                         {m_axis_tuser, m_axis_tlast, m_axis_tdata});
            end else begin
                exp_w = exp_q.pop_front();
                if ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== exp_w) begin
                    n_fail++;
                    $display("[TB] FAIL scoreboard_word: got %h, expected %h",
                             {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_w);
                end
            end
        end
    end

    task automatic drive(input logic [DW-1:0] d, input logic u, input logic l,
                         input bit expect_out, input logic rdy);
        @(posedge i_clk);
        #1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        m_axis_tready = rdy;
        if (expect_out) exp_q.push_back({u, l, d});
    endtask

    task automatic idle(input logic rdy);
        @(posedge i_clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = rdy;
    endtask

    task automatic test_reset();
        i_aresetn        = 1'b0;
        s_axis_tvalid    = 1'b0;
        s_axis_tdata     = '0;
        s_axis_tuser     = 1'b0;
        s_axis_tlast     = 1'b0;
        m_axis_tready    = 1'b0;
        i_clear_overflow = 1'b0;
        #2;
        n_checks++;
        if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== 11'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h, expected 000",
                     {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata});
        end
        n_checks++;
        if ({o_fill, o_overflow, o_dropped_frames} !== 22'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_status: got fill=%0d ovf=%b drop=%0d, expected 0/0/0",
                     o_fill, o_overflow, o_dropped_frames);
        end
        @(posedge i_clk);
        #1;
        i_aresetn = 1'b1;
    endtask

    task automatic test_pass_through();
        logic [DW+1:0] exp_w;
        for (int i = 0; i < 32; i++) begin
            drive(DW'(i + 1), (i == 0), (i % 8 == 7), 1'b1, 1'b1);
            @(negedge i_clk);
            if (i > 0) begin
                exp_w = {((i - 1) == 0), ((i - 1) % 8 == 7), DW'(i)};
                n_checks++;
                if (!m_axis_tvalid || {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== exp_w) begin
                    n_fail++;
                    $display("[TB] FAIL pass_latency: got v=%b %h, expected v=1 %h",
                             m_axis_tvalid, {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_w);
                end
                n_checks++;
                if (o_fill > 5'd1 || o_overflow !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL pass_fill: got fill=%0d ovf=%b, expected fill<=1 ovf=0",
                             o_fill, o_overflow);
                end
            end
        end
        idle(1'b1);
        repeat (3) @(negedge i_clk);
        n_checks++;
        if (o_fill !== 5'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL pass_drained: got fill=%0d pending=%0d, expected 0/0",
                     o_fill, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 10; k++) begin
            drive(DW'(8'hA0 + k), 1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge i_clk);
            if (k > 0) begin
                n_checks++;
                if (!m_axis_tvalid || m_axis_tdata !== 8'hA0) begin
                    n_fail++;
                    $display("[TB] FAIL bp_head_stable: got v=%b %h, expected v=1 a0",
                             m_axis_tvalid, m_axis_tdata);
                end
            end
        end
        idle(1'b0);
        @(negedge i_clk);
        n_checks++;
        if (o_fill !== 5'd10 || m_axis_tdata !== 8'hA0) begin
            n_fail++;
            $display("[TB] FAIL bp_fill: got fill=%0d head=%h, expected 10 a0", o_fill, m_axis_tdata);
        end
        idle(1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            n_checks++;
            if (!m_axis_tvalid || m_axis_tdata !== DW'(8'hA0 + k)) begin
                n_fail++;
                $display("[TB] FAIL bp_burst: got v=%b %h, expected v=1 %h",
                         m_axis_tvalid, m_axis_tdata, DW'(8'hA0 + k));
            end
        end
        @(negedge i_clk);
        n_checks++;
        if (o_fill !== 5'd0 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_empty: got fill=%0d v=%b, expected 0 0", o_fill, m_axis_tvalid);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 16; i++) drive(DW'(8'h30 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        @(negedge i_clk);
        n_checks++;
        if (o_fill !== 5'd16) begin
            n_fail++;
            $display("[TB] FAIL full_fill: got %0d, expected 16", o_fill);
        end
        drive(8'h55, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b0);
        @(negedge i_clk);
        n_checks++;
        if (o_fill !== 5'd16 || o_overflow !== 1'b0 || o_dropped_frames !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL full_rw: got fill=%0d ovf=%b drop=%0d, expected 16 0 0",
                     o_fill, o_overflow, o_dropped_frames);
        end
        idle(1'b1);
        repeat (18) @(negedge i_clk);
        n_checks++;
        if (o_fill !== 5'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL full_drain: got fill=%0d pending=%0d, expected 0/0",
                     o_fill, exp_q.size());
        end
    endtask

    task automatic test_overflow_resync();
        for (int i = 0; i < 16; i++) drive(DW'(8'h60 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        drive(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge i_clk);
        n_checks++;
        if (o_overflow !== 1'b1 || o_dropped_frames !== 16'd1 || o_fill !== 5'd16) begin
            n_fail++;
            $display("[TB] FAIL ovf_event: got ovf=%b drop=%0d fill=%0d, expected 1 1 16",
                     o_overflow, o_dropped_frames, o_fill);
        end
        drive(8'h78, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h79, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge i_clk);
        n_checks++;
        if (o_fill !== 5'd16 || o_dropped_frames !== 16'd1) begin
            n_fail++;
            $display("[TB] FAIL ovf_discard: got fill=%0d drop=%0d, expected 16 1",
                     o_fill, o_dropped_frames);
        end
        // Room is available here, but without tuser the word must still be dropped
        drive(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(8'h11, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(8'h13, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        repeat (20) @(negedge i_clk);
        n_checks++;
        if (o_fill !== 5'd0 || exp_q.size() != 0 || o_dropped_frames !== 16'd1) begin
            n_fail++;
            $display("[TB] FAIL ovf_resync: got fill=%0d pending=%0d drop=%0d, expected 0 0 1",
                     o_fill, exp_q.size(), o_dropped_frames);
        end
    endtask

    task automatic test_clear_collision();
        idle(1'b1);
        i_clear_overflow = 1'b1;
        idle(1'b1);
        i_clear_overflow = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (o_overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_alone: got ovf=%b, expected 0", o_overflow);
        end
        for (int i = 0; i < 16; i++) drive(DW'(8'h40 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        drive(8'h88, 1'b0, 1'b0, 1'b0, 1'b0);
        i_clear_overflow = 1'b1;
        idle(1'b0);
        i_clear_overflow = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (o_overflow !== 1'b1 || o_dropped_frames !== 16'd2) begin
            n_fail++;
            $display("[TB] FAIL clear_vs_set: got ovf=%b drop=%0d, expected 1 2",
                     o_overflow, o_dropped_frames);
        end
        // A start-of-frame that still does not fit costs a second frame
        drive(8'h89, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge i_clk);
        n_checks++;
        if (o_dropped_frames !== 16'd3 || o_fill !== 5'd16) begin
            n_fail++;
            $display("[TB] FAIL drop_sof_full: got drop=%0d fill=%0d, expected 3 16",
                     o_dropped_frames, o_fill);
        end
        idle(1'b1);
        repeat (18) @(negedge i_clk);
        drive(8'h90, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(8'h9A, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        repeat (3) @(negedge i_clk);
        n_checks++;
        if (o_fill !== 5'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL clear_resync: got fill=%0d pending=%0d, expected 0/0",
                     o_fill, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive(DW'(8'hB0 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        @(negedge i_clk);
        n_checks++;
        if (o_fill !== 5'd5 || m_axis_tvalid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_prefill: got fill=%0d v=%b, expected 5 1", o_fill, m_axis_tvalid);
        end
        #2;
        i_aresetn = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || o_fill !== 5'd0 || m_axis_tdata !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL rst_async: got v=%b fill=%0d data=%h, expected 0 0 00",
                     m_axis_tvalid, o_fill, m_axis_tdata);
        end
        @(posedge i_clk);
        #1;
        i_aresetn = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_fill !== 5'd0 || o_overflow !== 1'b0 || o_dropped_frames !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL rst_release: got fill=%0d ovf=%b drop=%0d, expected 0 0 0",
                     o_fill, o_overflow, o_dropped_frames);
        end
        drive(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        @(negedge i_clk);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== 10'h3C3) begin
            n_fail++;
            $display("[TB] FAIL rst_first_word: got v=%b %h, expected v=1 3c3",
                     m_axis_tvalid, {m_axis_tuser, m_axis_tlast, m_axis_tdata});
        end
        repeat (2) @(negedge i_clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL rst_pending: got %0d, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_backpressure();
        test_full_rw();
        test_overflow_resync();
        test_clear_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
